// File: rtl/ysyx_22040365_ifu_if.sv
// Fetch-stage bundle: instruction-memory req/ack, redirect input and the {inst,pc} handoff to ID.
// The master modport is the IFU side; the slave modport is memory, branch unit and decoder.
interface ysyx_22040365_ifu_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch: holds the PC, issues one imem request at a time and buffers the word for ID.
// Latency: ack in cycle N gives if_valid in cycle N+1; peak throughput is 1 inst per 2 cycles.
// Backpressure: no new fetch is issued while the buffered word waits for if_ready; redirect squashes it.
module ysyx_22040365_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22040365_ifu_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] req_addr, req_addr_n;
    logic [31:0] inst_q, inst_n;
    logic [63:0] inst_pc_q, inst_pc_n;
    logic [63:0] redir_pc;

    assign redir_pc = {bus.redirect_pc[63:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            inst_q    <= inst_n;
            inst_pc_q <= inst_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        inst_n     = inst_q;
        inst_pc_n  = inst_pc_q;
        case (state)
            IDLE: begin
                state_n    = WAIT;
                req_addr_n = pc;
                if (bus.redirect_valid) begin
                    pc_n       = redir_pc;
                    req_addr_n = redir_pc;
                end
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        // Returned word belongs to the squashed path; re-request at the target.
                        pc_n       = redir_pc;
                        req_addr_n = redir_pc;
                    end else begin
                        inst_n    = bus.imem_rdata;
                        inst_pc_n = req_addr;
                        pc_n      = req_addr + 64'd4;
                        state_n   = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    // Old request must stay stable until memory answers it.
                    pc_n    = redir_pc;
                    state_n = DROP;
                end
            end
            DROP: begin
                if (bus.redirect_valid) begin
                    pc_n = redir_pc;
                end
                if (bus.imem_ack) begin
                    req_addr_n = bus.redirect_valid ? redir_pc : pc;
                    state_n    = WAIT;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_n       = redir_pc;
                    req_addr_n = redir_pc;
                    state_n    = WAIT;
                end else if (bus.if_ready) begin
                    req_addr_n = pc;
                    state_n    = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.imem_req  = (state == WAIT) || (state == DROP);
    assign bus.imem_addr = req_addr;
    assign bus.if_valid  = (state == HOLD);
    assign bus.if_inst   = (state == HOLD) ? inst_q : NOP_INST;
    assign bus.if_pc     = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Directed bench for the fetch stage: inputs change and outputs are checked on the falling edge.
module tb_ysyx_22040365_ifu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ysyx_22040365_ifu_if bus();

    ysyx_22040365_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.if_ready       = 1'b0;
        @(negedge clk);
        step();

        // reset state
        chk("rst_req",   {63'h0, bus.imem_req}, 64'h0);
        chk("rst_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("rst_inst",  {32'h0, bus.if_inst},  64'h13);
        chk("rst_pc",    bus.if_pc,             64'h8000_0000);
        chk("rst_addr",  bus.imem_addr,         64'h8000_0000);

        // 1: zero-wait fetch
        rst = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0010_0093;
        step();
        chk("t1_req",  {63'h0, bus.imem_req}, 64'h1);
        chk("t1_addr", bus.imem_addr,         64'h8000_0000);
        step();
        chk("t1_valid", {63'h0, bus.if_valid}, 64'h1);
        chk("t1_inst",  {32'h0, bus.if_inst},  64'h0010_0093);
        chk("t1_pc",    bus.if_pc,             64'h8000_0000);

        // 2: ID stalls 5 cycles; stray acks must be ignored
        bus.imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_valid", {63'h0, bus.if_valid}, 64'h1);
            chk("t2_inst",  {32'h0, bus.if_inst},  64'h0010_0093);
            chk("t2_pc",    bus.if_pc,             64'h8000_0000);
            chk("t2_req",   {63'h0, bus.imem_req}, 64'h0);
        end
        bus.imem_ack = 1'b0;
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
        chk("t2_valid_off", {63'h0, bus.if_valid}, 64'h0);
        chk("t2_req_on",    {63'h0, bus.imem_req}, 64'h1);
        chk("t2_addr",      bus.imem_addr,         64'h8000_0004);

        // 3: redirect while waiting, ack arrives 3 cycles later
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0100;
        step();
        bus.redirect_valid = 1'b0;
        chk("t3_drop_req",  {63'h0, bus.imem_req}, 64'h1);
        chk("t3_drop_addr", bus.imem_addr,         64'h8000_0004);
        step();
        step();
        chk("t3_hold_addr", bus.imem_addr,         64'h8000_0004);
        chk("t3_no_valid",  {63'h0, bus.if_valid}, 64'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t3_new_addr",  bus.imem_addr,         64'h8000_0100);
        chk("t3_discard",   {63'h0, bus.if_valid}, 64'h0);
        bus.imem_rdata = 32'h0020_0113;
        step();
        chk("t3_valid", {63'h0, bus.if_valid}, 64'h1);
        chk("t3_inst",  {32'h0, bus.if_inst},  64'h0020_0113);
        chk("t3_pc",    bus.if_pc,             64'h8000_0100);

        // 4: redirect coincident with ack; target low bits dropped
        bus.imem_ack = 1'b0;
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
        chk("t4_addr0", bus.imem_addr, 64'h8000_0104);
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'h0000_0BAD;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0203;
        step();
        bus.redirect_valid = 1'b0;
        chk("t4_addr",  bus.imem_addr,         64'h8000_0200);
        chk("t4_valid", {63'h0, bus.if_valid}, 64'h0);
        bus.imem_rdata = 32'h0030_0193;
        step();
        bus.imem_ack = 1'b0;
        chk("t4_inst", {32'h0, bus.if_inst}, 64'h0030_0193);
        chk("t4_pc",   bus.if_pc,            64'h8000_0200);

        // 5: redirect beats if_ready in HOLD
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0400;
        bus.if_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b0;
        chk("t5_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("t5_req",   {63'h0, bus.imem_req}, 64'h1);
        chk("t5_addr",  bus.imem_addr,         64'h8000_0400);

        // 6: pc wrap at top of address space, then reset mid-WAIT
        bus.imem_ack       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("t6_addr_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.imem_rdata = 32'h0000_0013;
        step();
        chk("t6_pc_top", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.imem_ack = 1'b0;
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
        chk("t6_wrap", bus.imem_addr,         64'h0);
        chk("t6_req",  {63'h0, bus.imem_req}, 64'h1);
        rst = 1'b1;
        step();
        chk("t6_rst_req",  {63'h0, bus.imem_req}, 64'h0);
        chk("t6_rst_addr", bus.imem_addr,         64'h8000_0000);
        rst = 1'b0;
        step();
        chk("t6_restart_req",  {63'h0, bus.imem_req}, 64'h1);
        chk("t6_restart_addr", bus.imem_addr,         64'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
